// File: rtl/mc8051_mem_arbiter_pkg.sv
// Shared constants for the 8051 external memory arbiter: op codes,
// FSM state encodings, the timeout read-back value and the strobe bundle.
package mc8051_mem_arbiter_pkg;

  // Requester op codes
  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  // Access sequencer states
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GRANT  = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

  // Value returned to a reader whose access timed out
  localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;

  // Active-low memory strobes, kept together so they are always updated as one
  typedef struct packed {
    logic we_n;
    logic rd_n;
    logic psen_n;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{we_n: 1'b1, rd_n: 1'b1, psen_n: 1'b1};

  // Exactly one strobe low for a legal op; the reserved op drives none
  function automatic strobe_t strobe_decode(input logic [1:0] op);
    strobe_t s;
    s = STROBE_IDLE;
    case (op)
      OP_FETCH: s.psen_n = 1'b0;
      OP_READ:  s.rd_n   = 1'b0;
      OP_WRITE: s.we_n   = 1'b0;
      default:  s        = STROBE_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc8051_mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: port 0 (core BIU) and
// port 1 (debug/DMA loader).
//
// Handshake: a requester raises pN_req with pN_op/pN_addr/pN_wdata and keeps
// req high until pN_rdy pulses for one cycle. Address/data are captured one
// cycle after the grant decision; later changes, or dropping req, do not
// affect an access already granted. A req still high after pN_rdy is a new
// request.
interface mc8051_mem_arbiter_if;

  logic        p0_req;
  logic [1:0]  p0_op;
  logic [15:0] p0_addr;
  logic [7:0]  p0_wdata;
  logic        p0_rdy;

  logic        p1_req;
  logic [1:0]  p1_op;
  logic [15:0] p1_addr;
  logic [7:0]  p1_wdata;
  logic        p1_rdy;

  // Requester side
  modport master (
    output p0_req, p0_op, p0_addr, p0_wdata,
    output p1_req, p1_op, p1_addr, p1_wdata,
    input  p0_rdy, p1_rdy
  );

  // Arbiter side
  modport slave (
    input  p0_req, p0_op, p0_addr, p0_wdata,
    input  p1_req, p1_op, p1_addr, p1_wdata,
    output p0_rdy, p1_rdy
  );

endinterface

// File: rtl/mc8051_arb_pick.sv
// Winner selection for the memory arbiter. Port 0 wins by default; port 1
// wins when it is alone or when port 0 has been granted STARVE_MAX times in
// a row while port 1 was waiting.
module mc8051_arb_pick
  import mc8051_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          p0_req,
  input  logic          p1_req,
  input  logic [1:0]    state,
  output logic          winner,
  output logic [SW-1:0] starve_cnt
);

  logic starve_hit;

  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));
  assign winner     = p1_req & (~p0_req | starve_hit);

  // Count port-0 grants taken while port 1 waits; only IDLE makes decisions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (!p1_req) begin
        starve_cnt <= '0;
      end else if (winner) begin
        starve_cnt <= '0;
      end else if (p0_req && !starve_hit) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc8051_mem_arbiter.sv
// Two-port arbiter and access sequencer for the 8051 external memory bus.
// IDLE picks a winner, GRANT latches its address/data/op, ACCESS holds one
// strobe low until mem_data_rdy or timeout, DONE gives a strobe-high
// turnaround cycle and the one-cycle rdy (and err) pulse.
module mc8051_mem_arbiter
  import mc8051_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_W  = 4,
  parameter int STARVE_MAX = 3,
  parameter int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mc8051_mem_arbiter_if.slave   bus,
  output logic [7:0]            o_rdata,
  output logic                  o_err,
  output logic                  o_busy,
  output logic                  o_owner,
  output logic                  mem_we_n,
  output logic                  mem_rd_n,
  output logic                  mem_psen_n,
  output logic [15:0]           mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_data_rdy,
  input  logic [7:0]            mem_rdata,
  output logic [1:0]            dbg_state,
  output logic [SW-1:0]         dbg_starve
);

  // The counter reaches 2**TIMEOUT_W-1 on the increment made in the last
  // allowed ACCESS cycle, so that cycle is the one where it still reads one less.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  logic [1:0]           state;
  logic                 sel_q;
  logic [1:0]           op_q;
  logic [TIMEOUT_W-1:0] wait_cnt;
  strobe_t              strobe_q;
  logic                 winner;
  logic                 any_req;
  logic                 acc_end;

  logic [1:0]           sel_op;
  logic [15:0]          sel_addr;
  logic [7:0]           sel_wdata;

  mc8051_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .clk        (clk),
    .reset_n    (reset_n),
    .p0_req     (bus.p0_req),
    .p1_req     (bus.p1_req),
    .state      (state),
    .winner     (winner),
    .starve_cnt (dbg_starve)
  );

  assign any_req    = bus.p0_req | bus.p1_req;
  // rdy wins over a timeout that lands in the same cycle
  assign acc_end    = mem_data_rdy | (wait_cnt == WAIT_LAST);

  assign o_busy     = (state != ST_IDLE);
  assign dbg_state  = state;
  assign mem_we_n   = strobe_q.we_n;
  assign mem_rd_n   = strobe_q.rd_n;
  assign mem_psen_n = strobe_q.psen_n;

  // Route the request fields of the port chosen in IDLE to the GRANT latches
  always_comb begin
    sel_op    = bus.p0_op;
    sel_addr  = bus.p0_addr;
    sel_wdata = bus.p0_wdata;
    if (sel_q) begin
      sel_op    = bus.p1_op;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end
  end

  // Sequencer state, chosen port and wait-state counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      sel_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            sel_q <= winner;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          wait_cnt <= '0;
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (acc_end) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Bus-side latches and registered strobes; address/data frozen after GRANT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      op_q      <= OP_FETCH;
      o_owner   <= 1'b0;
      strobe_q  <= STROBE_IDLE;
    end else begin
      if (state == ST_GRANT) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        op_q      <= sel_op;
        o_owner   <= sel_q;
        strobe_q  <= strobe_decode(sel_op);
      end else if (state == ST_ACCESS && acc_end) begin
        strobe_q  <= STROBE_IDLE;
      end else if (state != ST_ACCESS) begin
        strobe_q  <= STROBE_IDLE;
      end
    end
  end

  // Completion: read data capture plus one-cycle rdy/err pulses shown in DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_rdata    <= 8'h00;
      o_err      <= 1'b0;
      bus.p0_rdy <= 1'b0;
      bus.p1_rdy <= 1'b0;
    end else begin
      o_err      <= 1'b0;
      bus.p0_rdy <= 1'b0;
      bus.p1_rdy <= 1'b0;
      if (state == ST_ACCESS && acc_end) begin
        if (op_q != OP_WRITE) begin
          o_rdata <= mem_data_rdy ? mem_rdata : RDATA_TIMEOUT;
        end
        o_err      <= ~mem_data_rdy;
        bus.p0_rdy <= ~o_owner;
        bus.p1_rdy <= o_owner;
      end
    end
  end

endmodule

// File: tb/tb_mc8051_mem_arbiter.sv
// Directed bench for mc8051_mem_arbiter: a transaction-timeline model of the
// arbiter is compared with the DUT every cycle, and each scenario ends with
// hand-computed literal expectations.
module tb_mc8051_mem_arbiter;

  localparam int TIMEOUT_W  = 4;
  localparam int STARVE_MAX = 3;
  localparam int SW         = 2;
  localparam int TMO_CYCLES = (1 << TIMEOUT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mc8051_mem_arbiter_if bus();

  logic [7:0]    o_rdata;
  logic          o_err, o_busy, o_owner;
  logic          mem_we_n, mem_rd_n, mem_psen_n;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_data_rdy = 1'b0;
  logic [7:0]    mem_rdata = 8'h00;
  logic [1:0]    dbg_state;
  logic [SW-1:0] dbg_starve;

  mc8051_mem_arbiter #(
    .TIMEOUT_W  (TIMEOUT_W),
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .o_rdata      (o_rdata),
    .o_err        (o_err),
    .o_busy       (o_busy),
    .o_owner      (o_owner),
    .mem_we_n     (mem_we_n),
    .mem_rd_n     (mem_rd_n),
    .mem_psen_n   (mem_psen_n),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_data_rdy (mem_data_rdy),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state),
    .dbg_starve   (dbg_starve)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // An access is a timeline: decided in an idle cycle, granted at cycle g,
  // strobe low from g+1 until the completion is known, rdy shown at cycle d.
  bit          m_active = 1'b0;
  bit          m_port   = 1'b0;
  logic [1:0]  m_op     = 2'b00;
  int          g        = 0;
  int          d        = -1;
  bit          m_err    = 1'b0;
  int          m_starve = 0;
  logic [15:0] e_addr   = 16'h0000;
  logic [7:0]  e_wdata  = 8'h00;
  logic [7:0]  e_rdata  = 8'h00;
  bit          e_owner  = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 1'b0; m_port = 1'b0; m_op = 2'b00; g = 0; d = -1; m_err = 1'b0;
      m_starve = 0; e_addr = 16'h0000; e_wdata = 8'h00; e_rdata = 8'h00; e_owner = 1'b0;
    end else if (m_active && d == cyc) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (bus.p0_req || bus.p1_req) begin
        m_port = bus.p1_req && (!bus.p0_req || m_starve == STARVE_MAX);
        m_active = 1'b1; g = cyc + 1; d = -1; m_err = 1'b0;
      end
      if (!bus.p1_req || m_port) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
    end else if (cyc == g) begin
      m_op    = m_port ? bus.p1_op    : bus.p0_op;
      e_addr  = m_port ? bus.p1_addr  : bus.p0_addr;
      e_wdata = m_port ? bus.p1_wdata : bus.p0_wdata;
      e_owner = m_port;
    end else if (d < 0) begin
      if (mem_data_rdy) begin
        d = cyc + 1;
        if (m_op != 2'b10) e_rdata = mem_rdata;
      end else if (cyc - g == TMO_CYCLES) begin
        d = cyc + 1; m_err = 1'b1;
        if (m_op != 2'b10) e_rdata = 8'hFF;
      end
    end
  end

  // Every-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    bit acc;
    if (reset_n) begin
      acc = m_active && cyc > g && d < 0;
      check("busy",    32'(o_busy),     32'(m_active));
      check("owner",   32'(o_owner),    32'(e_owner));
      check("psen_n",  32'(mem_psen_n), 32'(!(acc && m_op == 2'b00)));
      check("rd_n",    32'(mem_rd_n),   32'(!(acc && m_op == 2'b01)));
      check("we_n",    32'(mem_we_n),   32'(!(acc && m_op == 2'b10)));
      check("addr",    32'(mem_addr),   32'(e_addr));
      check("wdata",   32'(mem_wdata),  32'(e_wdata));
      check("rdata",   32'(o_rdata),    32'(e_rdata));
      check("p0_rdy",  32'(bus.p0_rdy), 32'(m_active && d == cyc && !m_port));
      check("p1_rdy",  32'(bus.p1_rdy), 32'(m_active && d == cyc && m_port));
      check("err",     32'(o_err),      32'(m_active && d == cyc && m_err));
    end
  end

  // ---------------- memory responder ----------------
  int         mem_wait = 0;
  logic [7:0] mem_val  = 8'h00;
  int         acc_cnt  = 0;

  always @(negedge clk) begin
    mem_rdata = mem_val;
    if (!mem_we_n || !mem_rd_n || !mem_psen_n) begin
      mem_data_rdy = (acc_cnt == mem_wait);
      acc_cnt++;
    end else begin
      mem_data_rdy = 1'b0;
      acc_cnt = 0;
    end
  end

  // ---------------- monitor ----------------
  int rd_low = 0, we_low = 0, psen_low = 0, err_cnt = 0, rdy_cnt = 0;
  int first_low = -1, rdy_cyc = -1, err_cyc = -1;
  logic [0:0] got_q[$];
  logic [0:0] exp_q[$];

  always @(negedge clk) begin
    if (!mem_rd_n) rd_low++;
    if (!mem_we_n) we_low++;
    if (!mem_psen_n) psen_low++;
    if ((!mem_rd_n || !mem_we_n || !mem_psen_n) && first_low < 0) first_low = cyc;
    if (bus.p0_rdy) begin got_q.push_back(1'b0); rdy_cnt++; if (rdy_cyc < 0) rdy_cyc = cyc; end
    if (bus.p1_rdy) begin got_q.push_back(1'b1); rdy_cnt++; if (rdy_cyc < 0) rdy_cyc = cyc; end
    if (o_err) begin err_cnt++; if (err_cyc < 0) err_cyc = cyc; end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counters();
    rd_low = 0; we_low = 0; psen_low = 0; err_cnt = 0; rdy_cnt = 0;
    first_low = -1; rdy_cyc = -1; err_cyc = -1;
    got_q.delete();
  endtask

  task automatic set_port(input bit port, input bit req, input logic [1:0] op,
                          input logic [15:0] addr, input logic [7:0] wdata);
    if (port) begin
      bus.p1_req = req; bus.p1_op = op; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end else begin
      bus.p0_req = req; bus.p0_op = op; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end
  endtask

  // One access from one port; drop=1 releases req and scrambles addr/wdata after grant
  task automatic do_access(input bit port, input logic [1:0] op, input logic [15:0] addr,
                           input logic [7:0] wdata, input int waits, input logic [7:0] rdata,
                           input bit drop, output int t0);
    bit seen;
    mem_wait = waits; mem_val = rdata;
    clear_counters();
    t0 = cyc;
    set_port(port, 1'b1, op, addr, wdata);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (drop && k == 1) set_port(port, 1'b0, op, 16'hDEAD, 8'hEE);
      if (port ? bus.p1_rdy : bus.p0_rdy) seen = 1'b1;
    end
    set_port(port, 1'b0, op, addr, wdata);
    check("rdy_seen", 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    bit found;
    set_port(1'b0, 1'b0, 2'b00, 16'h0000, 8'h00);
    set_port(1'b1, 1'b0, 2'b00, 16'h0000, 8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_rd_n", 32'(mem_rd_n), 32'd1);
    check("rst_we_n", 32'(mem_we_n), 32'd1);
    check("rst_psen", 32'(mem_psen_n), 32'd1);
    check("rst_addr", 32'(mem_addr), 32'h0000);
    check("rst_rdata", 32'(o_rdata), 32'h00);
    check("rst_busy", 32'(o_busy), 32'd0);

    // Zero-wait read, port 0
    do_access(1'b0, 2'b01, 16'h1234, 8'h00, 0, 8'hA5, 1'b0, t0);
    check("t1_rd_cycles", 32'(rd_low), 32'd1);
    check("t1_strobe_lat", 32'(first_low - t0), 32'd2);
    check("t1_rdy_lat", 32'(rdy_cyc - t0), 32'd3);
    check("t1_rdata", 32'(o_rdata), 32'hA5);
    check("t1_addr", 32'(mem_addr), 32'h1234);
    check("t1_err", 32'(err_cnt), 32'd0);

    // Write with 3 wait states, port 1
    do_access(1'b1, 2'b10, 16'h00FF, 8'h5A, 3, 8'h11, 1'b0, t0);
    check("t2_we_cycles", 32'(we_low), 32'd4);
    check("t2_rdy_pulses", 32'(rdy_cnt), 32'd1);
    check("t2_wdata", 32'(mem_wdata), 32'h5A);
    check("t2_rdata_kept", 32'(o_rdata), 32'hA5);

    // Simultaneous continuous requests: starvation guard order
    mem_wait = 0; mem_val = 8'h42;
    clear_counters();
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    set_port(1'b0, 1'b1, 2'b01, 16'h1000, 8'h00);
    set_port(1'b1, 1'b1, 2'b00, 16'h2000, 8'h00);
    for (int k = 0; k < 200 && got_q.size() < 8; k++) @(negedge clk);
    set_port(1'b0, 1'b0, 2'b01, 16'h1000, 8'h00);
    set_port(1'b1, 1'b0, 2'b00, 16'h2000, 8'h00);
    repeat (2) @(negedge clk);
    check("t3_grants", 32'(got_q.size()), 32'd8);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("t3_order", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    check("t3_rd_cycles", 32'(rd_low), 32'd6);
    check("t3_psen_cycles", 32'(psen_low), 32'd2);

    // Fetch timeout
    do_access(1'b0, 2'b00, 16'h0042, 8'h00, -1, 8'h77, 1'b0, t0);
    check("t4_psen_cycles", 32'(psen_low), 32'd15);
    check("t4_err", 32'(err_cnt), 32'd1);
    check("t4_err_with_rdy", 32'(err_cyc), 32'(rdy_cyc));
    check("t4_rdata", 32'(o_rdata), 32'hFF);

    // rdy on the last timeout cycle: rdy wins
    do_access(1'b0, 2'b01, 16'h0100, 8'h00, 14, 8'h3C, 1'b0, t0);
    check("t5_rd_cycles", 32'(rd_low), 32'd15);
    check("t5_err", 32'(err_cnt), 32'd0);
    check("t5_rdata", 32'(o_rdata), 32'h3C);

    // Req dropped and address scrambled after grant
    do_access(1'b1, 2'b01, 16'h0200, 8'h00, 2, 8'hC3, 1'b1, t0);
    check("t6_rdy_pulses", 32'(rdy_cnt), 32'd1);
    check("t6_rd_cycles", 32'(rd_low), 32'd3);
    check("t6_rdata", 32'(o_rdata), 32'hC3);
    check("t6_addr", 32'(mem_addr), 32'h0200);

    // Reserved op: no strobe, completes by timeout with error
    do_access(1'b0, 2'b11, 16'h0300, 8'h00, 0, 8'h00, 1'b0, t0);
    check("t7_no_strobe", 32'(rd_low + we_low + psen_low), 32'd0);
    check("t7_err", 32'(err_cnt), 32'd1);

    // Reset in the middle of a read
    mem_wait = -1; mem_val = 8'h55;
    clear_counters();
    set_port(1'b0, 1'b1, 2'b01, 16'h0400, 8'h00);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (!mem_rd_n) found = 1'b1;
    end
    check("t8_rd_low_seen", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t8_async_rd_n", 32'(mem_rd_n), 32'd1);
    check("t8_async_busy", 32'(o_busy), 32'd0);
    check("t8_async_addr", 32'(mem_addr), 32'h0000);
    check("t8_async_rdata", 32'(o_rdata), 32'h00);
    set_port(1'b0, 1'b0, 2'b01, 16'h0400, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t8_no_rdy", 32'(rdy_cnt), 32'd0);

    // Normal service resumes after reset
    do_access(1'b0, 2'b01, 16'h0500, 8'h00, 1, 8'h99, 1'b0, t0);
    check("t9_rdata", 32'(o_rdata), 32'h99);
    check("t9_rd_cycles", 32'(rd_low), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc8051_mem_arbiter.md
Name: mc8051_mem_arbiter

Overview:
Two-port arbiter and access sequencer for the naive external memory bus (we_n/rd_n/psen_n, 16-bit addr, 8-bit data, data_rdy).
- Port 0 is the core bus interface unit; port 1 is the debug/DMA loader.
- Latches the address and write data of the winning port and drives the strobes. It waits for mem_data_rdy, with a timeout, and returns read data plus a one-cycle ready pulse to the winner.
- Sits between the core BIU and the physical memory model/controller.

Parameters:
TIMEOUT_W, 4, width of wait-state counter; timeout after 2**TIMEOUT_W-1 cycles without mem_data_rdy
STARVE_MAX, 3, consecutive port-0 grants allowed while port 1 is pending before port 1 is forced

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 access request, held until p0_rdy
p0_op  in  2  port 0 op: 2'b00 code fetch (psen), 2'b01 data read (rd), 2'b10 data write (we), 2'b11 reserved
p0_addr  in  16  port 0 address
p0_wdata  in  8  port 0 write data
p0_rdy  out  1  one-cycle completion pulse to port 0
p1_req, p1_op, p1_addr, p1_wdata, p1_rdy  same as port 0, for port 1
o_rdata  out  8  read data of last completed access, held until next completion
o_err  out  1  one-cycle pulse coincident with pN_rdy when the access timed out
o_busy  out  1  high in GRANT/ACCESS/DONE
o_owner  out  1  port of current/last grant
mem_we_n, mem_rd_n, mem_psen_n  out  1 each  active-low strobes to memory
mem_addr  out  16  memory address
mem_wdata  out  8  memory write data
mem_data_rdy  in  1  memory completion
mem_rdata  in  8  memory read data

Behaviour:
- Reset: state IDLE; all strobes 1; mem_addr 16'h0000; mem_wdata 8'h00; o_rdata 8'h00; pN_rdy, o_err, o_busy, o_owner 0; counters 0. Reset is asynchronous: asserting reset mid-access raises the strobes immediately, and the access is lost.
- FSM states: IDLE, GRANT, ACCESS, DONE.
- IDLE:
  - If any req, select a winner and go to GRANT.
  - Winner is port 0 unless p1_req is high and starve_cnt==STARVE_MAX; then port 1 wins.
  - With only one req high, that port wins.
- starve_cnt:
  - Increments on each port-0 grant while p1_req is high, saturating at STARVE_MAX.
  - Clears on any port-1 grant, and in IDLE when p1_req is low.
- GRANT (1 cycle): latch winner addr/wdata/op into mem_addr/mem_wdata/op_q; set o_owner; clear wait counter; go to ACCESS.
- ACCESS:
  - Exactly one strobe low, per op_q: 00 psen_n, 01 rd_n, 10 we_n. Op 11 drives no strobe and completes after timeout with o_err.
  - mem_addr and mem_wdata are stable for the whole access.
  - mem_data_rdy is sampled each cycle. When high: capture mem_rdata into o_rdata (reads/fetches only; writes leave o_rdata unchanged) and go to DONE.
  - Wait counter increments each ACCESS cycle. When it reaches 2**TIMEOUT_W-1 without rdy: o_rdata<=8'hFF (reads) and go to DONE with the error flag set.
  - If rdy and timeout occur in the same cycle, rdy wins and there is no error.
- DONE (1 cycle):
  - Strobes all high; pulse rdy of the owner; pulse o_err if flagged; go to IDLE.
  - Guarantees at least one strobe-high cycle between consecutive accesses (turnaround).
- Latency: req seen in IDLE at cycle 0 -> strobe low at cycle 2. With zero-wait memory (rdy high the first ACCESS cycle), pN_rdy pulses at cycle 3. The next grant is earliest cycle 4.
- A requester dropping req after grant does not abort the access; it completes and pulses rdy anyway. A req held high after rdy is treated as a new request in IDLE.
- Changes on the non-owner port, or owner addr/wdata changes after GRANT, do not affect the current access.
- pN_rdy and o_err are registered outputs; strobes are registered, decoded from state and op_q.

Decomposition:
- Shared package / global_param.v: op encodings (OP_FETCH=2'b00, OP_READ=2'b01, OP_WRITE=2'b10), FSM state encodings (ST_IDLE/ST_GRANT/ST_ACCESS/ST_DONE), and the timeout read-back value 8'hFF.
- One natural sub-module: mc8051_arb_pick. It is combinational plus the starve_cnt register, takes p0_req, p1_req and state, and outputs winner and starve_cnt. The top holds the FSM, address/data latches and the wait counter.

Test Plan:
- Zero-wait read, port 0: p0_req, op 01, addr 16'h1234, memory rdy on first ACCESS cycle with rdata 8'hA5. Required: mem_rd_n low exactly 1 cycle at cycle 2, mem_addr 16'h1234; p0_rdy at cycle 3; o_rdata 8'hA5; o_err 0.
- Write with 3 wait states, port 1: op 10, addr 16'h00FF, wdata 8'h5A, rdy after 3 cycles. Required: mem_we_n low 4 cycles; mem_wdata 8'h5A stable throughout; p1_rdy one pulse; o_rdata unchanged.
- Simultaneous requests: p0 and p1 held continuously. Required: grants go p0,p0,p0,p1,p0,p0,p0,p1 (STARVE_MAX=3); strobes high at least 1 cycle between accesses.
- Timeout: fetch op 00, mem_data_rdy never asserted, TIMEOUT_W=4. Required: mem_psen_n low 15 cycles; then p0_rdy and o_err pulse together; o_rdata 8'hFF.
- Reset mid-access: assert reset_n=0 during ACCESS with rd_n low. Required: strobes high asynchronously; all outputs at reset values; after release, no rdy pulse for the aborted access.
- Req dropped after grant plus the same-cycle rdy/timeout edge case. Required: the access completes with a rdy pulse; when rdy coincides with the last timeout cycle, o_err is 0 and o_rdata equals mem_rdata.
